// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits on a registered, idle-high TX line.
module uart_tx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin,
  output logic       tx_busy
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  shift_q, shift_d;
  logic        pin_q, pin_d;
  logic        bit_end;
  logic        par_bit;

  assign bit_end = (cnt_q == CYCLE_LAST);
  // Odd parity makes the total count of ones odd, so it is the inverse of the XOR.
  assign par_bit = (PARITY == 1) ? ~^shift_q : ^shift_q;

  assign tx_data_ready = (state_q == S_IDLE) && !rst;
  assign tx_busy       = (state_q != S_IDLE);
  assign tx_pin        = pin_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    pin_d   = pin_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        pin_d = 1'b1;
        if (tx_data_valid && tx_data_ready) begin
          state_d = S_START;
          shift_d = tx_data;
          bit_d   = 3'd0;
          pin_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          pin_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              pin_d   = par_bit;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              pin_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            pin_d = shift_q[bit_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          pin_d   = 1'b1;
        end
      end
      S_STOP: begin
        pin_d = 1'b1;
        if (bit_end) begin
          if (STOP_BITS == 1 || stop_q) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        pin_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'd0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, even parity, odd parity with 2 stop bits) checked
// clock-by-clock against an expected line waveform built from each handshaken byte.
module tb_uart_tx;

  localparam int CYC     = 10;
  localparam int PAR [3] = '{0, 2, 1};
  localparam int STP [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst   [3];
  logic [7:0] data  [3];
  logic       valid [3];
  logic       ready [3];
  logic       pin   [3];
  logic       busy  [3];

  always #5 clk = ~clk;

  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .tx_data(data[0]), .tx_data_valid(valid[0]),
    .tx_data_ready(ready[0]), .tx_pin(pin[0]), .tx_busy(busy[0])
  );
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(data[1]), .tx_data_valid(valid[1]),
    .tx_data_ready(ready[1]), .tx_pin(pin[1]), .tx_busy(busy[1])
  );
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .tx_data(data[2]), .tx_data_valid(valid[2]),
    .tx_data_ready(ready[2]), .tx_pin(pin[2]), .tx_busy(busy[2])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         hs     [3];
  bit         in_frame [3];
  int         idx    [3];
  logic [7:0] cur    [3];
  logic [7:0] rxb    [3];
  int         end_cyc [3];
  int         frames [3];
  bit         b2b    [3];
  logic       pop_ok;
  logic [7:0] pop_b;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return CYC * (10 + ((PAR[i] != 0) ? 1 : 0) + STP[i] - 1);
  endfunction

  // Expected line level k clocks into the frame carrying byte b.
  function automatic logic exp_level(input int i, input logic [7:0] b, input int k);
    int bitn;
    int ones;
    bitn = k / CYC;
    ones = 0;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    if (bitn == 9 && PAR[i] != 0) begin
      for (int j = 0; j < 8; j++) ones += int'(b[j]);
      return (PAR[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
    end
    return 1'b1;
  endfunction

  task automatic push_exp(input int i, input logic [7:0] b);
    hs[i]++;
    case (i)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic ok, output logic [7:0] b);
    ok = 1'b0;
    b  = 8'd0;
    case (i)
      0: if (q0.size() > 0) begin b = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin b = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Monitor: decodes every frame on the line and checks it against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        chk("ready_in_rst", i, 32'(ready[i]), 32'd0);
        in_frame[i] = 1'b0;
      end else if (in_frame[i]) begin
        chk("pin", i, 32'(pin[i]), 32'(exp_level(i, cur[i], idx[i])));
        chk("busy_in_frame", i, 32'(busy[i]), 32'd1);
        chk("ready_in_frame", i, 32'(ready[i]), 32'd0);
        if (idx[i] % CYC == CYC / 2 && idx[i] / CYC >= 1 && idx[i] / CYC <= 8)
          rxb[i][idx[i] / CYC - 1] = pin[i];
        idx[i]++;
        if (idx[i] == frame_len(i)) begin
          in_frame[i] = 1'b0;
          end_cyc[i]  = cyc;
          frames[i]++;
          chk("rx_byte", i, 32'(rxb[i]), 32'(cur[i]));
        end
      end else if (pin[i] === 1'b0) begin
        pop_exp(i, pop_ok, pop_b);
        if (!pop_ok) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame inst%0d cycle %0d: got start bit expected idle", i, cyc);
          in_frame[i] = 1'b1;
          cur[i]      = 8'hxx;
          idx[i]      = 1;
        end else begin
          if (b2b[i]) chk("idle_gap", i, 32'(cyc - end_cyc[i]), 32'd2);
          chk("start_busy", i, 32'(busy[i]), 32'd1);
          cur[i]      = pop_b;
          rxb[i]      = 8'd0;
          idx[i]      = 1;
          in_frame[i] = 1'b1;
        end
      end else begin
        chk("idle_pin", i, 32'(pin[i]), 32'd1);
        chk("idle_busy", i, 32'(busy[i]), 32'd0);
        chk("idle_ready", i, 32'(ready[i]), 32'd1);
      end
    end
  end

  task automatic send(input int i, input logic [7:0] b, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    data[i]  = b;
    valid[i] = 1'b1;
    while (!ready[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout inst%0d: got ready=0 expected ready=1", i);
      valid[i] = 1'b0;
    end else begin
      push_exp(i, b);
      @(posedge clk);
      #1;
      if (!keep) valid[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while ((busy[i] !== 1'b0 || in_frame[i]) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout inst%0d: got busy=%0b expected busy=0", i, busy[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; data[i] = 8'd0; b2b[i] = 1'b0;
      hs[i] = 0; frames[i] = 0; in_frame[i] = 1'b0; idx[i] = 0; end_cyc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    send(0, 8'h55, 1'b0);
    wait_idle(0);

    // Valid held high across two bytes: exactly one idle clock between frames.
    send(0, 8'hA3, 1'b1);
    @(negedge clk);
    #1 b2b[0] = 1'b1;
    send(0, 8'h0F, 1'b1);
    valid[0] = 1'b0;
    wait_idle(0);
    b2b[0] = 1'b0;

    // Data changes after the handshake and a valid pulse while busy must both be ignored.
    send(0, 8'h3C, 1'b0);
    data[0] = 8'hC3;
    repeat (30) @(negedge clk);
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);

    // One-clock reset during data bit 3 aborts the frame.
    send(0, 8'hFF, 1'b0);
    repeat (44) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    send(0, 8'h81, 1'b0);
    wait_idle(0);

    send(1, 8'h07, 1'b0);
    wait_idle(1);
    send(2, 8'h07, 1'b0);
    wait_idle(2);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) begin
        send(i, 8'($urandom_range(0, 255)), 1'b0);
        wait_idle(i);
      end
    end

    // Loopback-style stream of every byte value, back to back.
    send(0, 8'h00, 1'b1);
    @(negedge clk);
    #1 b2b[0] = 1'b1;
    for (int k = 1; k < 256; k++) send(0, 8'(k), 1'b1);
    valid[0] = 1'b0;
    wait_idle(0);
    b2b[0] = 1'b0;
    repeat (5) @(negedge clk);

    chk("frame_count", 0, 32'(frames[0]), 32'(hs[0] - 1));
    chk("frame_count", 1, 32'(frames[1]), 32'(hs[1]));
    chk("frame_count", 2, 32'(frames[2]), 32'(hs[2]));
    chk("queue_empty", 0, 32'(q0.size()), 32'd0);
    chk("queue_empty", 1, 32'(q1.size()), 32'd0);
    chk("queue_empty", 2, 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
